// File: rtl/fetch_align.sv
// Halfword realignment queue between instruction memory and the decoder.
// Splits fetched words into 16/32-bit instructions, tracking their PCs.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mem_rdata, mem_valid, mem_ready word fetch handshake
//   redirect, redirect_pc           flush and restart at a new PC
//   ins_out, ins_pc, ins_is_comp    instruction, its PC, 16-bit flag
//   ins_valid, ins_ready            instruction handshake
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ins_out,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic        ins_is_comp
);

    logic [15:0] hq [4];
    logic [15:0] hq_n [4];
    logic [2:0]  count;
    logic [2:0]  count_n;
    logic        drop_low;
    logic        drop_n;
    logic [31:0] pc;
    logic [31:0] pc_n;

    logic        head_comp;
    logic        word_xfer;
    logic        ins_xfer;
    logic [2:0]  pop;
    logic [2:0]  push;
    logic [2:0]  base;

    // Bit 0 of the redirect target is architecturally always zero.
    logic        unused_bit0;
    assign unused_bit0 = redirect_pc[0];

    assign head_comp = (hq[0][1:0] != 2'b11);
    assign mem_ready = (count <= 3'd2) && !redirect;
    assign word_xfer = mem_valid && mem_ready;
    assign ins_xfer  = ins_valid && ins_ready;
    assign ins_pc    = pc;

    always_comb begin
        ins_valid   = 1'b0;
        ins_out     = 32'h0000_0000;
        ins_is_comp = 1'b0;
        if (count >= 3'd1 && head_comp) begin
            ins_valid   = 1'b1;
            ins_out     = {16'h0000, hq[0]};
            ins_is_comp = 1'b1;
        end else if (count >= 3'd2 && !head_comp) begin
            ins_valid   = 1'b1;
            ins_out     = {hq[1], hq[0]};
        end
    end

    assign pop  = !ins_xfer ? 3'd0 : (ins_is_comp ? 3'd1 : 3'd2);
    assign push = !word_xfer ? 3'd0 : (drop_low ? 3'd1 : 3'd2);
    // Tail slot after the pop; push only happens when count <= 2,
    // so base + 1 never exceeds 3.
    assign base = count - pop;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hq_n[i] = hq[i];
        end
        if (pop == 3'd1) begin
            hq_n[0] = hq[1];
            hq_n[1] = hq[2];
            hq_n[2] = hq[3];
        end else if (pop == 3'd2) begin
            hq_n[0] = hq[2];
            hq_n[1] = hq[3];
        end
        for (int i = 0; i < 4; i++) begin
            if (word_xfer && i == int'(base)) begin
                hq_n[i] = drop_low ? mem_rdata[31:16]
                                   : mem_rdata[15:0];
            end else if (word_xfer && !drop_low
                         && i == int'(base) + 1) begin
                hq_n[i] = mem_rdata[31:16];
            end
        end
        count_n = count - pop + push;
        pc_n    = pc + {28'd0, pop, 1'b0};
        drop_n  = word_xfer ? 1'b0 : drop_low;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                hq[i] <= 16'h0000;
            end
            count    <= 3'd0;
            drop_low <= RESET_PC[1];
            pc       <= RESET_PC;
        end else if (redirect) begin
            count    <= 3'd0;
            drop_low <= redirect_pc[1];
            pc       <= {redirect_pc[31:1], 1'b0};
        end else begin
            for (int i = 0; i < 4; i++) begin
                hq[i] <= hq_n[i];
            end
            count    <= count_n;
            drop_low <= drop_n;
            pc       <= pc_n;
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: stimulus queues expected
// instructions, a negedge monitor pops and compares on each transfer.
module tb_fetch_align;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] ins_out;
    logic [31:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic        ins_is_comp;

    fetch_align dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins_out     (ins_out),
        .ins_pc      (ins_pc),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_is_comp (ins_is_comp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic expect_ins(input logic [31:0] ins,
                              input logic [31:0] pc,
                              input logic comp);
        exp_t x;
        x.ins  = ins;
        x.pc   = pc;
        x.comp = comp;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst_n && !redirect && ins_valid && ins_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ins got=%h want=none",
                         ins_out);
            end else begin
                e = q.pop_front();
                chk("ins_out", ins_out, e.ins);
                chk("ins_pc", ins_pc, e.pc);
                chk("ins_is_comp", {31'd0, ins_is_comp},
                    {31'd0, e.comp});
            end
        end
    end

    // Entered and left at posedge + 1.
    task automatic put_word(input logic [31:0] w);
        bit done = 0;
        mem_valid = 1'b1;
        mem_rdata = w;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (mem_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        mem_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL put_word_timeout got=busy want=accepted");
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && q.size() != 0; k++) begin
            @(negedge clk);
        end
        chk("drain", q.size(), 0);
        q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] p);
        redirect    = 1'b1;
        redirect_pc = p;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("redir_valid", {31'd0, ins_valid}, 32'd0);
        chk("redir_pc", ins_pc, {p[31:1], 1'b0});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst_out", ins_out, 32'd0);
        chk("rst_comp", {31'd0, ins_is_comp}, 32'd0);
        chk("rst_pc", ins_pc, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_mem_ready", {31'd0, mem_ready}, 32'd1);
        @(posedge clk);
        #1;
        ins_ready = 1'b1;

        expect_ins(32'h0000_0013, 32'd0, 1'b0);
        expect_ins(32'h0010_0093, 32'd4, 1'b0);
        put_word(32'h0000_0013);
        put_word(32'h0010_0093);
        drain();

        do_redirect(32'd0);
        expect_ins(32'h0000_0505, 32'd0, 1'b1);
        expect_ins(32'h0000_4505, 32'd2, 1'b1);
        put_word(32'h4505_0505);
        drain();

        do_redirect(32'd0);
        expect_ins(32'h0000_0505, 32'd0, 1'b1);
        expect_ins(32'h0010_0093, 32'd2, 1'b0);
        expect_ins(32'h0000_0505, 32'd6, 1'b1);
        put_word(32'h0093_0505);
        @(posedge clk);
        @(negedge clk);
        chk("straddle_wait", {31'd0, ins_valid}, 32'd0);
        chk("straddle_pc", ins_pc, 32'd2);
        @(posedge clk);
        #1;
        put_word(32'h0505_0010);
        drain();

        do_redirect(32'd0);
        ins_ready = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 32'h0000_0013;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) chk("bp_ready0", {31'd0, mem_ready}, 32'd1);
            if (c >= 1) begin
                chk("bp_valid", {31'd0, ins_valid}, 32'd1);
                chk("bp_hold", ins_out, 32'h0000_0013);
            end
            if (c >= 2) chk("bp_full", {31'd0, mem_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        expect_ins(32'h0000_0013, 32'd0, 1'b0);
        expect_ins(32'h0000_0013, 32'd4, 1'b0);
        ins_ready = 1'b1;
        drain();

        do_redirect(32'h0000_0102);
        expect_ins(32'h0000_ABCD, 32'h0000_0102, 1'b1);
        put_word(32'hABCD_0001);
        drain();

        do_redirect(32'hFFFF_FFFE);
        expect_ins(32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        put_word(32'h0001_0000);
        drain();
        @(negedge clk);
        chk("wrap_pc", ins_pc, 32'd0);
        @(posedge clk);
        #1;

        ins_ready = 1'b0;
        do_redirect(32'h0000_0002);
        put_word(32'h0013_0000);
        put_word(32'h0000_0013);
        @(negedge clk);
        chk("cnt3_ready", {31'd0, mem_ready}, 32'd0);
        chk("cnt3_out", ins_out, 32'h0013_0013);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ins_valid}, 32'd0);
        chk("arst_out", ins_out, 32'd0);
        chk("arst_ready", {31'd0, mem_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_valid", {31'd0, ins_valid}, 32'd0);
        chk("post_ready", {31'd0, mem_ready}, 32'd1);
        chk("post_pc", ins_pc, 32'd0);
        chk("sb_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
